// File: rtl/rv_mem_arbiter.sv
// Arbitrates one single-port fixed-latency memory between instruction fetch and data access.
// Data port has priority; a starvation guard forces a fetch grant after STARVE_LIM data grants.
module rv_mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imem_req,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_rdata,
  output logic              imem_ack,
  input  logic              dmem_req,
  input  logic              dmem_we,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              owner_d_q, owner_d_d;  // 1 = data port owns the access
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] imem_rdata_q, imem_rdata_d;
  logic [DATA_W-1:0] dmem_rdata_q, dmem_rdata_d;
  logic              imem_ack_q, imem_ack_d;
  logic              dmem_ack_q, dmem_ack_d;
  logic              grant_i;

  // Next-state, grant and capture logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    starve_d     = starve_q;
    owner_d_d    = owner_d_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    imem_rdata_d = imem_rdata_q;
    dmem_rdata_d = dmem_rdata_q;
    imem_ack_d   = 1'b0;
    dmem_ack_d   = 1'b0;
    grant_i      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!imem_req) begin
          starve_d = '0;
        end
        if (imem_req || dmem_req) begin
          grant_i  = imem_req && (!dmem_req || (starve_q == CNT_W'(STARVE_LIM)));
          state_d  = S_BUSY;
          cnt_d    = '0;
          mem_en_d = 1'b1;
          if (grant_i) begin
            owner_d_d  = 1'b0;
            mem_addr_d = imem_addr;
            mem_we_d   = 1'b0;
            starve_d   = '0;
          end else begin
            owner_d_d   = 1'b1;
            mem_addr_d  = dmem_addr;
            mem_we_d    = dmem_we;
            mem_wdata_d = dmem_wdata;
            if (imem_req && (starve_q != CNT_W'(STARVE_LIM))) begin
              starve_d = starve_q + CNT_W'(1);
            end
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == CNT_W'(MEM_LAT)) begin
          state_d = S_DONE;
          if (owner_d_q) begin
            dmem_ack_d = 1'b1;
            if (!mem_we_q) begin
              dmem_rdata_d = mem_rdata;
            end
          end else begin
            imem_ack_d   = 1'b1;
            imem_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      starve_q     <= '0;
      owner_d_q    <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      imem_rdata_q <= '0;
      dmem_rdata_q <= '0;
      imem_ack_q   <= 1'b0;
      dmem_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      starve_q     <= starve_d;
      owner_d_q    <= owner_d_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      imem_rdata_q <= imem_rdata_d;
      dmem_rdata_q <= dmem_rdata_d;
      imem_ack_q   <= imem_ack_d;
      dmem_ack_q   <= dmem_ack_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign imem_rdata = imem_rdata_q;
  assign dmem_rdata = dmem_rdata_q;
  assign imem_ack   = imem_ack_q;
  assign dmem_ack   = dmem_ack_q;

  // Pipeline stall requests are combinational on the live request lines
  assign stall_if  = imem_req & ~imem_ack_q;
  assign stall_mem = dmem_req & ~dmem_ack_q;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Randomized bench for rv_mem_arbiter: a transaction-level reference model schedules the
// expected mem_en / ack cycles of each grant and a small memory model answers accesses.
module tb_rv_mem_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned LAT  = 2;
  localparam int unsigned SLIM = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_req, dmem_req, dmem_we;
  logic [AW-1:0] imem_addr, dmem_addr;
  logic [DW-1:0] dmem_wdata, mem_rdata;
  logic [DW-1:0] imem_rdata, dmem_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          imem_ack, dmem_ack, mem_en, mem_we, stall_if, stall_mem;

  always #5 clk = ~clk;

  rv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_LIM(SLIM)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit armed    = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Memory model: 16 words selected by address bits [5:2]
  logic [DW-1:0] mem [16];
  int            rd_cyc = -1;
  logic [DW-1:0] rd_val;

  // Reference model: one transaction at a time, timed from its grant cycle
  int unsigned   starve = 0;
  int            free_at = 0, en_cyc = -1, ack_cyc = -1, post_rst = -1;
  bit            own_d;
  logic [AW-1:0] g_addr;
  logic          g_we;
  logic [DW-1:0] g_wdata, g_rdata;
  logic [DW-1:0] e_irdata = '0, e_drdata = '0, e_wdata_hold = '0;
  bit            i_acked = 1'b0, d_acked = 1'b0;

  task automatic step(input int p_i, input int p_d, input int p_rst, input bit force_rst);
    bit exp_iack, exp_dack;
    @(posedge clk);
    #1;
    cyc++;
    // Requesters hold until acked, then drop or raise a fresh request
    if (i_acked || !imem_req) begin
      imem_req  = ($urandom_range(99) < p_i);
      imem_addr = AW'($urandom_range(15)) << 2;
    end
    if (d_acked || !dmem_req) begin
      dmem_req   = ($urandom_range(99) < p_d);
      dmem_we    = 1'($urandom_range(1));
      dmem_addr  = AW'($urandom_range(15)) << 2;
      dmem_wdata = $urandom;
    end
    reset     = force_rst || ($urandom_range(999) < p_rst);
    mem_rdata = (cyc == rd_cyc) ? rd_val : $urandom;

    @(negedge clk);
    exp_iack = (cyc == ack_cyc) && !own_d;
    exp_dack = (cyc == ack_cyc) && own_d;
    if (cyc == ack_cyc) begin
      if (own_d) begin
        if (!g_we) e_drdata = g_rdata;
      end else begin
        e_irdata = g_rdata;
      end
    end

    if (armed) begin
      check_eq("imem_ack", 32'(imem_ack), 32'(exp_iack));
      check_eq("dmem_ack", 32'(dmem_ack), 32'(exp_dack));
      check_eq("imem_rdata", imem_rdata, e_irdata);
      check_eq("dmem_rdata", dmem_rdata, e_drdata);
      check_eq("mem_en", 32'(mem_en), 32'(cyc == en_cyc));
      check_eq("stall_if", 32'(stall_if), 32'(imem_req && !exp_iack));
      check_eq("stall_mem", 32'(stall_mem), 32'(dmem_req && !exp_dack));
      if (en_cyc >= 0 && cyc >= en_cyc && cyc <= en_cyc + int'(LAT)) begin
        check_eq("mem_addr", mem_addr, g_addr);
        check_eq("mem_we", 32'(mem_we), 32'(g_we));
        check_eq("mem_wdata", mem_wdata, g_wdata);
      end
      if (cyc == post_rst) begin
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mem_we", 32'(mem_we), 32'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
      end
    end

    // Memory reacts to the strobe it actually sees
    if (mem_en === 1'b1) begin
      if (mem_we) begin
        mem[mem_addr[5:2]] = mem_wdata;
      end else begin
        rd_cyc = cyc + int'(LAT);
        rd_val = mem[mem_addr[5:2]];
      end
    end

    i_acked = exp_iack;
    d_acked = exp_dack;

    if (reset) begin
      en_cyc = -1; ack_cyc = -1; free_at = cyc + 1; starve = 0;
      e_irdata = '0; e_drdata = '0; e_wdata_hold = '0; post_rst = cyc + 1;
      armed = 1'b1;
    end else if (cyc >= free_at) begin
      if (!imem_req) starve = 0;
      if (imem_req || dmem_req) begin
        own_d = dmem_req && !(imem_req && starve == SLIM);
        if (own_d) begin
          g_addr = dmem_addr; g_we = dmem_we; g_wdata = dmem_wdata;
          e_wdata_hold = dmem_wdata;
          if (imem_req && starve < SLIM) starve++;
        end else begin
          g_addr = imem_addr; g_we = 1'b0; g_wdata = e_wdata_hold;
          starve = 0;
        end
        g_rdata = mem[g_addr[5:2]];
        en_cyc  = cyc + 1;
        ack_cyc = cyc + 2 + int'(LAT);
        free_at = cyc + 3 + int'(LAT);
      end
    end
  endtask

  initial begin
    reset = 1'b1; imem_req = 1'b0; dmem_req = 1'b0; dmem_we = 1'b0;
    imem_addr = '0; dmem_addr = '0; dmem_wdata = '0; mem_rdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[4] = 32'h0050_0093;

    step(0, 0, 0, 1'b1);
    step(0, 0, 0, 1'b1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1'b0);     // idle window
    for (int i = 0; i < 1500; i++) step(90, 90, 0, 1'b0); // contention, starvation guard
    for (int i = 0; i < 1500; i++) step(30, 30, 5, 1'b0); // sparse with reset pulses
    for (int i = 0; i < 1000; i++) step(10, 80, 0, 1'b0); // data-heavy
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
